cv32e40p_instr_obi_arbiter: RTL and testbench
=============================================

Name: cv32e40p_instr_obi_arbiter

Overview:
Two-requester arbiter for the single core instruction OBI port. Requester 0 is the prefetch buffer in the IF stage; requester 1 is the secondary fetch client (debug program-buffer / cache-fill path).
- Keeps the issued request stable until it is granted, as OBI requires.
- Tracks outstanding transactions in an in-order ID FIFO, so each rvalid/rdata/err goes back to the requester that issued it.
- Sits between the IF-stage fetch logic and the core's instr_* bus pins.

Parameters:
MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO (1..4); no new request is issued while the FIFO is full.
ADDR_WIDTH, 32, instruction address width.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset; takes effect on the clk edge where it is sampled high.
m0_req_i  in  1  requester 0 (prefetch) request.
m0_addr_i  in  ADDR_WIDTH  requester 0 address; word aligned.
m0_gnt_o  out  1  requester 0 grant.
m0_rvalid_o  out  1  requester 0 response valid.
m0_rdata_o  out  32  requester 0 response data.
m0_err_o  out  1  requester 0 response error.
m1_req_i / m1_addr_i / m1_gnt_o / m1_rvalid_o / m1_rdata_o / m1_err_o  same widths  requester 1.
instr_req_o  out  1  bus request.
instr_addr_o  out  ADDR_WIDTH  bus address.
instr_gnt_i  in  1  bus grant.
instr_rvalid_i  in  1  bus response valid.
instr_rdata_i  in  32  bus response data.
instr_err_i  in  1  bus response error.
outstanding_o  out  3  number of granted transactions not yet answered.
busy_o  out  1  high when instr_req_o=1 or outstanding_o!=0.
unexp_rvalid_o  out  1  sticky flag: rvalid received while the FIFO was empty.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, round-robin last-winner = 1 (so requester 0 wins first).
- FSM states:
  - IDLE: nothing is being presented to the bus.
  - HOLD0: requester 0 is being presented and is not yet granted.
  - HOLD1: requester 1 is being presented and is not yet granted.
- IDLE behaviour:
  - If FIFO not full and some m*_req_i is high, pick a winner; the bus sees the winner's req/addr combinationally in the same cycle.
  - instr_gnt_i=1 that cycle: push the winner's ID, pulse m*_gnt_o for the winner, stay in IDLE.
  - instr_gnt_i=0: go to HOLD0 or HOLD1.
- HOLD0 / HOLD1 behaviour:
  - Selection is frozen and the held requester's addr is forwarded.
  - Other requests are ignored, even a higher-priority one.
  - On instr_gnt_i=1: push the ID, pulse the grant, return to IDLE.
  - A new grant in that same cycle is not possible; the next arbitration happens the following cycle.
- Grant path: m*_gnt_o = instr_gnt_i AND instr_req_o AND (selected == m*). Combinational, zero latency.
- FIFO full: instr_req_o=0. The FSM does not enter HOLD; requesters stall with req held.
- Response routing:
  - instr_rvalid_i pops the FIFO head; rdata/err go combinationally to the requester named by the head ID.
  - The other requester's rvalid stays 0. rdata outputs may carry bus data at all times.
- Same cycle push and pop: FIFO count unchanged. Pop-then-push ordering, so a full FIFO may accept a grant in the same cycle as a pop.
  - Because of this, the full check uses (count==MAX_OUTSTANDING AND NOT instr_rvalid_i).
- rvalid while FIFO empty: no m*_rvalid_o, count stays 0, unexp_rvalid_o set. It is cleared only by rst.
- outstanding_o equals the FIFO count, in 0..MAX_OUTSTANDING.
- Reset mid-operation: FIFO flushed, FSM to IDLE. Responses to pre-reset grants that arrive after reset are treated as unexpected.
- The arbiter does not check requester protocol. Dropping req while in HOLD is illegal; the arbiter keeps presenting the held address until it is granted.

Optional Feature:
INSTR_ARB_ROUND_ROBIN_EN
- Defined: when both requests are high in IDLE, the requester that did not win the previous grant is chosen. The last-winner register updates on every grant.
- Undefined: fixed priority, requester 0 always beats requester 1; no last-winner register is built.

Test Plan:
- Single requester, instr_gnt_i tied 1, rvalid 1 cycle later; m0 issues addr 0x100, 0x104, 0x108 → instr_addr_o follows, m0_gnt_o=1 each cycle, m0_rvalid_o returns data 0xA,0xB,0xC in order, m1 outputs 0.
- Grant stall: m0 req addr 0x200 with gnt low for 3 cycles; m1 requests at cycle 1 → instr_addr_o stays 0x200 for all 4 cycles, m1_gnt_o=0; m1 is granted the cycle after m0's grant.
- Simultaneous requests for 4 cycles, gnt=1, MAX_OUTSTANDING=2, immediate rvalid → with INSTR_ARB_ROUND_ROBIN_EN grants alternate m0,m1,m0,m1; without it m0 gets all 4.
- FIFO full: MAX_OUTSTANDING=2, two grants with no rvalid → third request sees instr_req_o=0, outstanding_o=2. rvalid plus a pending request in the same cycle → grant issued, outstanding_o stays 2.
- Interleaved routing: grant m0(0x10), m1(0x20), then rvalid with rdata 0x11 (err=0) and 0x22 (err=1) → m0_rvalid_o gets 0x11 err 0, then m1_rvalid_o gets 0x22 err 1.
- Reset with 2 outstanding, then an rvalid → outstanding_o=0 after reset, no m*_rvalid_o, unexp_rvalid_o=1 and stays 1 until the next rst.

Source files
------------

// File: rtl/cv32e40p_instr_obi_arbiter.sv
// Two-requester arbiter for the core instruction OBI port, with in-order ID FIFO for response routing.
// Optional INSTR_ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests (default: requester 0 has priority).
module cv32e40p_instr_obi_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  output logic                  m0_err_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  m1_err_o,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [31:0]           instr_rdata_i,
  input  logic                  instr_err_i,
  output logic [2:0]            outstanding_o,
  output logic                  busy_o,
  output logic                  unexp_rvalid_o
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned PTR_W = 2;

  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_e;

  state_e           state_q, state_d;
  logic [3:0]       id_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             unexp_q;
  logic             sel;
  logic             push;
  logic             pop;
  logic             full;
  logic             head_id;
  logic             both_pick;

`ifdef INSTR_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Last-winner register; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (push) begin
      last_q <= sel;
    end
  end

  assign both_pick = ~last_q;
`else
  assign both_pick = 1'b0;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop in the same cycle frees the slot the new grant needs.
  assign full    = (cnt_q == CNT_W'(MAX_OUTSTANDING)) && !instr_rvalid_i;
  assign push    = instr_req_o && instr_gnt_i;
  assign pop     = instr_rvalid_i && (cnt_q != '0);
  assign head_id = id_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Selection and hold: the presented request stays frozen until granted.
  always_comb begin
    state_d      = state_q;
    instr_req_o  = 1'b0;
    sel          = 1'b0;
    instr_addr_o = '0;
    case (state_q)
      IDLE: begin
        if (!full && (m0_req_i || m1_req_i)) begin
          instr_req_o = 1'b1;
          sel         = (m0_req_i && m1_req_i) ? both_pick : m1_req_i;
          if (!instr_gnt_i) begin
            state_d = sel ? HOLD1 : HOLD0;
          end
        end
      end
      HOLD0: begin
        instr_req_o = 1'b1;
        sel         = 1'b0;
        if (instr_gnt_i) begin
          state_d = IDLE;
        end
      end
      HOLD1: begin
        instr_req_o = 1'b1;
        sel         = 1'b1;
        if (instr_gnt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (instr_req_o) begin
      instr_addr_o = sel ? m1_addr_i : m0_addr_i;
    end
  end

  // Outstanding-ID FIFO; pop reads the head before a same-cycle push overwrites a freed slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      unexp_q  <= 1'b0;
    end else begin
      if (push) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (instr_rvalid_i && (cnt_q == '0)) begin
        unexp_q <= 1'b1;
      end
    end
  end

  assign m0_gnt_o       = push && !sel;
  assign m1_gnt_o       = push && sel;
  assign m0_rvalid_o    = pop && !head_id;
  assign m1_rvalid_o    = pop && head_id;
  assign m0_err_o       = pop && !head_id && instr_err_i;
  assign m1_err_o       = pop && head_id && instr_err_i;
  assign m0_rdata_o     = instr_rdata_i;
  assign m1_rdata_o     = instr_rdata_i;
  assign outstanding_o  = cnt_q;
  assign busy_o         = instr_req_o || (cnt_q != '0);
  assign unexp_rvalid_o = unexp_q;

endmodule

// File: tb/tb_cv32e40p_instr_obi_arbiter.sv
// Bench for cv32e40p_instr_obi_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_cv32e40p_instr_obi_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
  logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] instr_rdata_i;
  logic [2:0]  outstanding_o;
  logic        busy_o, unexp_rvalid_o;

  int n_cmp = 0;
  int n_bad = 0;

  cv32e40p_instr_obi_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .outstanding_o(outstanding_o), .busy_o(busy_o), .unexp_rvalid_o(unexp_rvalid_o)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: held requester, queue of issued IDs, last winner, sticky unexpected flag.
  int   idq[$];
  int   held   = -1;
  int   last_w = 1;
  logic unexp_m = 1'b0;

  always @(negedge clk) begin
    logic        ereq, esel, epop, ehead, fullm;
    logic [31:0] eaddr;
    if (rst) begin
      idq.delete();
      held    = -1;
      last_w  = 1;
      unexp_m = 1'b0;
    end else begin
      fullm = (idq.size() == MAXO) && !instr_rvalid_i;
      ereq  = 1'b0;
      esel  = 1'b0;
      if (held >= 0) begin
        ereq = 1'b1;
        esel = (held == 1);
      end else if (!fullm && (m0_req_i || m1_req_i)) begin
        ereq = 1'b1;
        if (m0_req_i && m1_req_i) begin
`ifdef INSTR_ARB_ROUND_ROBIN_EN
          esel = (last_w == 0);
`else
          esel = 1'b0;
`endif
        end else begin
          esel = m1_req_i;
        end
      end
      eaddr = !ereq ? 32'h0 : (esel ? m1_addr_i : m0_addr_i);
      epop  = instr_rvalid_i && (idq.size() != 0);
      ehead = epop ? (idq[0] == 1) : 1'b0;

      chk1("model req", instr_req_o, ereq);
      if (ereq) chk32("model addr", instr_addr_o, eaddr);
      chk1("model m0_gnt", m0_gnt_o, ereq && instr_gnt_i && !esel);
      chk1("model m1_gnt", m1_gnt_o, ereq && instr_gnt_i && esel);
      chk1("model m0_rvalid", m0_rvalid_o, epop && !ehead);
      chk1("model m1_rvalid", m1_rvalid_o, epop && ehead);
      chk1("model m0_err", m0_err_o, epop && !ehead && instr_err_i);
      chk1("model m1_err", m1_err_o, epop && ehead && instr_err_i);
      if (epop && !ehead) chk32("model m0_rdata", m0_rdata_o, instr_rdata_i);
      if (epop && ehead)  chk32("model m1_rdata", m1_rdata_o, instr_rdata_i);
      chk32("model outstanding", 32'(outstanding_o), 32'(idq.size()));
      chk1("model busy", busy_o, ereq || (idq.size() != 0));
      chk1("model unexp", unexp_rvalid_o, unexp_m);

      if (instr_rvalid_i && idq.size() == 0) unexp_m = 1'b1;
      if (epop) void'(idq.pop_front());
      if (ereq && instr_gnt_i) begin
        idq.push_back(esel ? 1 : 0);
        last_w = esel ? 1 : 0;
        held   = -1;
      end else if (ereq) begin
        held = esel ? 1 : 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                     input logic g, input logic rv, input logic [31:0] rd, input logic er);
    step();
    m0_req_i = r0; m0_addr_i = a0; m1_req_i = r1; m1_addr_i = a1;
    instr_gnt_i = g; instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = er;
    #1;
  endtask

  initial begin
    logic w;
    rst = 1'b1;
    m0_req_i = 0; m0_addr_i = 0; m1_req_i = 0; m1_addr_i = 0;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0; instr_err_i = 0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk1("reset req", instr_req_o, 1'b0);
    chk32("reset outstanding", 32'(outstanding_o), 32'd0);
    chk1("reset busy", busy_o, 1'b0);
    chk1("reset unexp", unexp_rvalid_o, 1'b0);

    // Single requester streaming with immediate responses.
    drv(1, 32'h100, 0, 0, 1, 0, 0, 0);
    chk32("t1 addr0", instr_addr_o, 32'h100);
    chk1("t1 gnt0", m0_gnt_o, 1'b1);
    drv(1, 32'h104, 0, 0, 1, 1, 32'hA, 0);
    chk32("t1 addr1", instr_addr_o, 32'h104);
    chk1("t1 rvalid A", m0_rvalid_o, 1'b1);
    chk32("t1 rdata A", m0_rdata_o, 32'hA);
    drv(1, 32'h108, 0, 0, 1, 1, 32'hB, 0);
    chk32("t1 rdata B", m0_rdata_o, 32'hB);
    chk1("t1 m1_rvalid", m1_rvalid_o, 1'b0);
    drv(0, 0, 0, 0, 1, 1, 32'hC, 0);
    chk1("t1 rvalid C", m0_rvalid_o, 1'b1);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk32("t1 drained", 32'(outstanding_o), 32'd0);

    // Grant stall: held address must not switch to m1.
    drv(1, 32'h200, 0, 0, 0, 0, 0, 0);
    chk32("t2 addr c0", instr_addr_o, 32'h200);
    drv(1, 32'h200, 1, 32'h300, 0, 0, 0, 0);
    chk32("t2 addr c1", instr_addr_o, 32'h200);
    drv(1, 32'h200, 1, 32'h300, 0, 0, 0, 0);
    chk1("t2 m1_gnt c2", m1_gnt_o, 1'b0);
    drv(1, 32'h200, 1, 32'h300, 1, 0, 0, 0);
    chk32("t2 addr c3", instr_addr_o, 32'h200);
    chk1("t2 m0_gnt c3", m0_gnt_o, 1'b1);
    chk1("t2 m1_gnt c3", m1_gnt_o, 1'b0);
    drv(0, 0, 1, 32'h300, 1, 0, 0, 0);
    chk1("t2 m1_gnt c4", m1_gnt_o, 1'b1);
    chk32("t2 addr c4", instr_addr_o, 32'h300);
    drv(0, 0, 0, 0, 0, 1, 32'h55, 0);
    chk1("t2 m0 resp", m0_rvalid_o, 1'b1);
    drv(0, 0, 0, 0, 0, 1, 32'h66, 0);
    chk1("t2 m1 resp", m1_rvalid_o, 1'b1);

    // Simultaneous requests: alternate with round robin, else m0 always.
    for (int i = 0; i < 4; i++) begin
      drv(1, 32'h600 + 32'(4 * i), 1, 32'h700 + 32'(4 * i), 1, (i > 0), 32'hD0 + 32'(i), 0);
`ifdef INSTR_ARB_ROUND_ROBIN_EN
      w = ((i % 2) == 1);
`else
      w = 1'b0;
`endif
      chk1("t3 m0_gnt", m0_gnt_o, !w);
      chk1("t3 m1_gnt", m1_gnt_o, w);
    end
    drv(0, 0, 0, 0, 0, 1, 32'hD4, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk32("t3 drained", 32'(outstanding_o), 32'd0);

    // FIFO full, then grant accepted in the same cycle as a pop.
    drv(1, 32'h400, 0, 0, 1, 0, 0, 0);
    drv(1, 32'h404, 0, 0, 1, 0, 0, 0);
    drv(0, 0, 1, 32'h500, 1, 0, 0, 0);
    chk1("t4 full req", instr_req_o, 1'b0);
    chk32("t4 full cnt", 32'(outstanding_o), 32'd2);
    chk1("t4 full m1_gnt", m1_gnt_o, 1'b0);
    drv(0, 0, 1, 32'h500, 1, 1, 32'h77, 0);
    chk1("t4 pop+push req", instr_req_o, 1'b1);
    chk1("t4 pop+push gnt", m1_gnt_o, 1'b1);
    chk1("t4 pop m0", m0_rvalid_o, 1'b1);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk32("t4 cnt stays", 32'(outstanding_o), 32'd2);
    drv(0, 0, 0, 0, 0, 1, 32'h88, 0);
    chk1("t4 drain m0", m0_rvalid_o, 1'b1);
    drv(0, 0, 0, 0, 0, 1, 32'h99, 0);
    chk1("t4 drain m1", m1_rvalid_o, 1'b1);

    // Interleaved routing with error on the second response.
    drv(1, 32'h10, 0, 0, 1, 0, 0, 0);
    drv(0, 0, 1, 32'h20, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 32'h11, 0);
    chk1("t5 m0 rvalid", m0_rvalid_o, 1'b1);
    chk32("t5 m0 rdata", m0_rdata_o, 32'h11);
    chk1("t5 m0 err", m0_err_o, 1'b0);
    drv(0, 0, 0, 0, 0, 1, 32'h22, 1);
    chk1("t5 m1 rvalid", m1_rvalid_o, 1'b1);
    chk32("t5 m1 rdata", m1_rdata_o, 32'h22);
    chk1("t5 m1 err", m1_err_o, 1'b1);
    chk1("t5 m0 quiet", m0_rvalid_o, 1'b0);

    // Reset with two outstanding; late response is unexpected.
    drv(1, 32'h30, 0, 0, 1, 0, 0, 0);
    drv(0, 0, 1, 32'h40, 1, 0, 0, 0);
    step();
    m1_req_i = 0; instr_gnt_i = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk32("t6 cnt after rst", 32'(outstanding_o), 32'd0);
    chk1("t6 unexp after rst", unexp_rvalid_o, 1'b0);
    drv(0, 0, 0, 0, 0, 1, 32'h5A, 0);
    chk1("t6 no m0_rvalid", m0_rvalid_o, 1'b0);
    chk1("t6 no m1_rvalid", m1_rvalid_o, 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk1("t6 unexp set", unexp_rvalid_o, 1'b1);
    chk32("t6 cnt zero", 32'(outstanding_o), 32'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk1("t6 unexp sticky", unexp_rvalid_o, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk1("t6 unexp cleared", unexp_rvalid_o, 1'b0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
